// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter
//   Owns the single video-memory port (VRAM 8000-9FFF, OAM FE00-FE9F) and shares it between the
//   CPU, the PPU fetcher and the OAM DMA engine started by a write to FF46.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   CPU_ADDR/WR/RD/DATA_out          CPU MMIO bus in; CPU_DATA_in read data out (combinational)
//   LCD_EN, PPU_MODE                 LCDC[7] and current PPU mode (0 HBLANK .. 3 DRAW)
//   PPU_RD, PPU_ADDR, PPU_DATA_in    PPU fetch request and its data (combinational)
//   VMEM_ADDR/WR/WDATA/RDATA         video RAM port (asynchronous read)
//   SRC_ADDR/RD/RDATA                DMA source read on the system bus (asynchronous read)
//   DMA_ACTIVE                       high while the DMA engine is in START or XFER
module oam_dma_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] CPU_ADDR,
   input  logic        CPU_WR,
   input  logic        CPU_RD,
   input  logic [7:0]  CPU_DATA_out,
   output logic [7:0]  CPU_DATA_in,
   input  logic        LCD_EN,
   input  logic [1:0]  PPU_MODE,
   input  logic        PPU_RD,
   input  logic [15:0] PPU_ADDR,
   output logic [7:0]  PPU_DATA_in,
   output logic [15:0] VMEM_ADDR,
   output logic        VMEM_WR,
   output logic [7:0]  VMEM_WDATA,
   input  logic [7:0]  VMEM_RDATA,
   output logic [15:0] SRC_ADDR,
   output logic        SRC_RD,
   input  logic [7:0]  SRC_RDATA,
   output logic        DMA_ACTIVE
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StStart = 2'd1;
   localparam logic [1:0] StXfer  = 2'd2;

   localparam logic [7:0]  OamLast = 8'd159;
   localparam logic [15:0] OamBase = 16'hFE00;

   logic [1:0] state_q, state_d;
   logic [7:0] idx_q, idx_d;
   logic [7:0] page_q, page_d;

   logic cpu_vram, cpu_oam, cpu_unusable, cpu_dma_reg;
   logic ppu_vram, ppu_oam;
   logic xfer, dma_start, ppu_owned, ppu_grant, cpu_blocked, cpu_grant;
   logic [7:0] src_page;

   // Address decode
   assign cpu_vram     = (CPU_ADDR[15:13] == 3'b100);
   assign cpu_oam      = (CPU_ADDR[15:8] == 8'hFE) && (CPU_ADDR[7:0] < 8'hA0);
   assign cpu_unusable = (CPU_ADDR[15:8] == 8'hFE) && (CPU_ADDR[7:0] >= 8'hA0);
   assign cpu_dma_reg  = (CPU_ADDR == 16'hFF46);
   assign ppu_vram     = (PPU_ADDR[15:13] == 3'b100);
   assign ppu_oam      = (PPU_ADDR[15:8] == 8'hFE) && (PPU_ADDR[7:0] < 8'hA0);

   assign dma_start  = CPU_WR && cpu_dma_reg;
   assign xfer       = (state_q == StXfer);
   assign DMA_ACTIVE = (state_q != StIdle);

   // Pages E0-FF are the echo of C000-DFFF
   assign src_page = (page_q >= 8'hE0) ? (page_q - 8'h20) : page_q;

   assign ppu_owned = LCD_EN && (((PPU_MODE == 2'd2) && ppu_oam) ||
                                 ((PPU_MODE == 2'd3) && (ppu_vram || ppu_oam)));
   assign ppu_grant = !xfer && PPU_RD && ppu_owned;

   // OAM is locked in modes 2 and 3 (PPU_MODE[1]) and for the whole DMA, including START
   assign cpu_blocked = cpu_vram ? (LCD_EN && (PPU_MODE == 2'd3))
                                 : (DMA_ACTIVE || (LCD_EN && PPU_MODE[1]));
   assign cpu_grant   = (CPU_RD || CPU_WR) && (cpu_vram || cpu_oam) && !cpu_blocked &&
                        !xfer && !ppu_grant;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      page_d  = page_q;
      case (state_q)
         StIdle: ;
         StStart: begin
            state_d = StXfer;
            idx_d   = 8'd0;
         end
         StXfer: begin
            if (idx_q == OamLast) begin
               state_d = StIdle;
               idx_d   = 8'd0;
            end else begin
               idx_d = idx_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
      // A write to FF46 overrides everything; the current XFER byte has already been driven
      if (dma_start) begin
         state_d = StStart;
         idx_d   = 8'd0;
         page_d  = CPU_DATA_out;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= 8'd0;
         page_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         page_q  <= page_d;
      end
   end

   // Video port mux: DMA, then PPU, then CPU
   always_comb begin
      VMEM_ADDR  = 16'h0000;
      VMEM_WR    = 1'b0;
      VMEM_WDATA = 8'h00;
      SRC_RD     = 1'b0;
      SRC_ADDR   = 16'h0000;
      if (xfer) begin
         SRC_RD     = 1'b1;
         SRC_ADDR   = {src_page, idx_q};
         VMEM_WR    = 1'b1;
         VMEM_ADDR  = OamBase + {8'h00, idx_q};
         VMEM_WDATA = SRC_RDATA;
      end else if (ppu_grant) begin
         VMEM_ADDR = PPU_ADDR;
      end else if (cpu_grant) begin
         VMEM_ADDR  = CPU_ADDR;
         VMEM_WR    = CPU_WR;
         VMEM_WDATA = CPU_WR ? CPU_DATA_out : 8'h00;
      end
   end

   assign PPU_DATA_in = ppu_grant ? VMEM_RDATA : 8'hFF;

   always_comb begin
      CPU_DATA_in = 8'hFF;
      if (CPU_RD) begin
         if (cpu_dma_reg) begin
            CPU_DATA_in = page_q;
         end else if (cpu_unusable) begin
            CPU_DATA_in = 8'h00;
         end else if (cpu_grant) begin
            CPU_DATA_in = VMEM_RDATA;
         end
      end
   end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: directed scenarios plus randomized accesses,
// checked against a behavioural model of the memory map and the DMA timeline.
module tb_oam_dma_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] CPU_ADDR;
   logic        CPU_WR, CPU_RD;
   logic [7:0]  CPU_DATA_out, CPU_DATA_in;
   logic        LCD_EN;
   logic [1:0]  PPU_MODE;
   logic        PPU_RD;
   logic [15:0] PPU_ADDR;
   logic [7:0]  PPU_DATA_in;
   logic [15:0] VMEM_ADDR;
   logic        VMEM_WR;
   logic [7:0]  VMEM_WDATA, VMEM_RDATA;
   logic [15:0] SRC_ADDR;
   logic        SRC_RD;
   logic [7:0]  SRC_RDATA;
   logic        DMA_ACTIVE;

   always #5 clk = ~clk;

   oam_dma_arbiter dut (
      .clk(clk), .rst(rst),
      .CPU_ADDR(CPU_ADDR), .CPU_WR(CPU_WR), .CPU_RD(CPU_RD),
      .CPU_DATA_out(CPU_DATA_out), .CPU_DATA_in(CPU_DATA_in),
      .LCD_EN(LCD_EN), .PPU_MODE(PPU_MODE), .PPU_RD(PPU_RD), .PPU_ADDR(PPU_ADDR),
      .PPU_DATA_in(PPU_DATA_in),
      .VMEM_ADDR(VMEM_ADDR), .VMEM_WR(VMEM_WR), .VMEM_WDATA(VMEM_WDATA),
      .VMEM_RDATA(VMEM_RDATA),
      .SRC_ADDR(SRC_ADDR), .SRC_RD(SRC_RD), .SRC_RDATA(SRC_RDATA),
      .DMA_ACTIVE(DMA_ACTIVE)
   );

   // Bench-side memories: the video RAM the DUT drives, the system bus, and the model's view
   logic [7:0] vmem   [0:65535];
   logic [7:0] srcmem [0:65535];
   logic [7:0] mdl    [0:65535];
   logic [7:0] page_mdl;

   assign VMEM_RDATA = vmem[VMEM_ADDR];
   assign SRC_RDATA  = srcmem[SRC_ADDR];

   always @(posedge clk) begin
      if (VMEM_WR) vmem[VMEM_ADDR] <= VMEM_WDATA;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic bit is_vram(input logic [15:0] a);
      return (a >= 16'h8000) && (a <= 16'h9FFF);
   endfunction

   function automatic bit is_oam(input logic [15:0] a);
      return (a >= 16'hFE00) && (a <= 16'hFE9F);
   endfunction

   function automatic bit is_unusable(input logic [15:0] a);
      return (a >= 16'hFEA0) && (a <= 16'hFEFF);
   endfunction

   function automatic logic [7:0] mirror_page(input logic [7:0] p);
      return (p >= 8'hE0) ? p - 8'h20 : p;
   endfunction

   function automatic logic [15:0] pick_addr(input bit allow_reg);
      case ($urandom_range(0, 4))
         0:       return 16'h8000 + 16'($urandom_range(0, 16'h1FFF));
         1:       return 16'hFE00 + 16'($urandom_range(0, 8'h9F));
         2:       return 16'hFEA0 + 16'($urandom_range(0, 8'h5F));
         3:       return allow_reg ? 16'hFF46 : 16'hFF40;
         default: return 16'hC000 + 16'($urandom_range(0, 16'h0FFF));
      endcase
   endfunction

   // One access with the DMA idle. Called at posedge+1; returns at the next posedge+1.
   task automatic idle_access(input logic lcd, input logic [1:0] mode, input logic rd,
                              input logic wr, input logic [15:0] ca, input logic [7:0] d,
                              input logic prd, input logic [15:0] pa);
      bit ppu_g, cpu_g, cpu_blk;
      logic [7:0] exp_cpu, exp_ppu;
      LCD_EN = lcd; PPU_MODE = mode; CPU_RD = rd; CPU_WR = wr; CPU_ADDR = ca;
      CPU_DATA_out = d; PPU_RD = prd; PPU_ADDR = pa;
      ppu_g = prd && lcd && (((mode == 2'd2) && is_oam(pa)) ||
                             ((mode == 2'd3) && (is_vram(pa) || is_oam(pa))));
      cpu_blk = is_vram(ca) ? (lcd && mode == 2'd3) : (lcd && mode >= 2'd2);
      cpu_g = (rd || wr) && (is_vram(ca) || is_oam(ca)) && !cpu_blk && !ppu_g;
      exp_ppu = ppu_g ? mdl[pa] : 8'hFF;
      if (!rd)                                    exp_cpu = 8'hFF;
      else if (ca == 16'hFF46)                    exp_cpu = page_mdl;
      else if (is_unusable(ca))                   exp_cpu = 8'h00;
      else if (cpu_g)                             exp_cpu = mdl[ca];
      else                                        exp_cpu = 8'hFF;
      @(negedge clk);
      check("idle_dma_active", DMA_ACTIVE, 0);
      check("cpu_data", CPU_DATA_in, exp_cpu);
      check("ppu_data", PPU_DATA_in, exp_ppu);
      check("vmem_wr", VMEM_WR, wr && cpu_g);
      if (ppu_g)      check("vmem_addr_ppu", VMEM_ADDR, pa);
      else if (cpu_g) check("vmem_addr_cpu", VMEM_ADDR, ca);
      if (wr && cpu_g) begin
         check("vmem_wdata", VMEM_WDATA, d);
         mdl[ca] = d;
      end
      @(posedge clk); #1;
      CPU_RD = 1'b0; CPU_WR = 1'b0; PPU_RD = 1'b0;
   endtask

   // Runs one DMA from an FF46 write of pg, following the timeline cycle by cycle.
   // restart_at / abort_at are XFER byte indices (-1 = never).
   task automatic dma_run(input logic [7:0] pg, input int restart_at, input logic [7:0] pg2,
                          input int abort_at, input bit rand_cpu);
      int k, idx, active, exp_total, op;
      bit pend, restarted, done, aborted, xfer, cpu_rd_on, ppu_rd_on;
      logic [7:0] cur, pend_pg, idx8;
      logic [15:0] sa;
      CPU_ADDR = 16'hFF46; CPU_WR = 1'b1; CPU_DATA_out = pg; page_mdl = pg;
      k = 0; pend = 1; pend_pg = pg; cur = pg; active = 0;
      restarted = 0; done = 0; aborted = 0; exp_total = 161;
      for (int cyc = 0; cyc < 400 && !done && !aborted; cyc++) begin
         @(posedge clk); #1;
         CPU_WR = 1'b0; CPU_RD = 1'b0; PPU_RD = 1'b0;
         cpu_rd_on = 0; ppu_rd_on = 0;
         if (pend) begin
            k = 1; cur = pend_pg; pend = 0;
         end else if (k >= 1 && k <= 161) begin
            k++;
         end
         xfer = (k >= 2) && (k <= 161);
         idx  = k - 2;
         idx8 = idx[7:0];
         if (xfer && !restarted && idx == restart_at) begin
            CPU_ADDR = 16'hFF46; CPU_WR = 1'b1; CPU_DATA_out = pg2;
            pend = 1; pend_pg = pg2; page_mdl = pg2; restarted = 1;
            exp_total = idx + 2 + 161;
         end else if (xfer && rand_cpu) begin
            if (idx == 16)      op = 1;
            else if (idx == 32) op = 2;
            else if (idx == 4)  op = 3;
            else                op = int'($urandom_range(0, 3));
            case (op)
               1: begin
                  CPU_RD = 1'b1; cpu_rd_on = 1;
                  CPU_ADDR = (idx == 16) ? 16'hFE10 : 16'hFE00 + 16'($urandom_range(0, 159));
               end
               2: begin
                  CPU_WR = 1'b1;
                  CPU_ADDR = (idx == 32) ? 16'hFE20 : 16'hFE00 + 16'($urandom_range(0, 159));
                  CPU_DATA_out = (idx == 32) ? 8'h55 : 8'($urandom);
               end
               3: begin
                  PPU_RD = 1'b1; ppu_rd_on = 1;
                  PPU_ADDR = (idx == 4) ? 16'hFE04 : 16'hFE00 + 16'($urandom_range(0, 159));
               end
               default: ;
            endcase
         end
         if (xfer && idx == abort_at) begin
            rst = 1'b1;
            #1;
            check("abort_dma_active", DMA_ACTIVE, 0);
            check("abort_vmem_wr", VMEM_WR, 0);
            check("abort_src_rd", SRC_RD, 0);
            rst = 1'b0;
            page_mdl = 8'h00;
            aborted = 1;
         end else begin
            @(negedge clk);
            sa = {mirror_page(cur), idx8};
            check("dma_active", DMA_ACTIVE, (k >= 1) && (k <= 161));
            check("src_rd", SRC_RD, xfer);
            check("dma_vmem_wr", VMEM_WR, xfer);
            if (xfer) begin
               check("src_addr", SRC_ADDR, sa);
               check("dma_vmem_addr", VMEM_ADDR, 16'hFE00 + 16'(idx));
               check("dma_vmem_wdata", VMEM_WDATA, srcmem[sa]);
               mdl[16'hFE00 + 16'(idx)] = srcmem[sa];
            end
            if (cpu_rd_on) check("locked_cpu_rd", CPU_DATA_in, 8'hFF);
            if (ppu_rd_on) check("collide_ppu_rd", PPU_DATA_in, 8'hFF);
            if ((k >= 1) && (k <= 161)) active++;
            if (k == 162) done = 1;
         end
      end
      @(posedge clk); #1;
      CPU_WR = 1'b0; CPU_RD = 1'b0; PPU_RD = 1'b0;
      check("dma_finished", done || aborted, 1);
      if (!aborted) check("active_cycles", active, exp_total);
   endtask

   task automatic check_oam();
      for (int i = 0; i < 160; i++) check("oam", vmem[16'hFE00 + 16'(i)], mdl[16'hFE00 + 16'(i)]);
   endtask

   initial begin
      logic [15:0] a, pa;
      int sel;
      for (int i = 0; i < 65536; i++) begin
         srcmem[i] = 8'($urandom);
         vmem[i]   = 8'($urandom);
         mdl[i]    = vmem[i];
      end
      page_mdl = 8'h00;
      rst = 1'b1; CPU_ADDR = 16'h0000; CPU_WR = 1'b0; CPU_RD = 1'b0; CPU_DATA_out = 8'h00;
      LCD_EN = 1'b0; PPU_MODE = 2'd0; PPU_RD = 1'b0; PPU_ADDR = 16'h0000;
      #2;
      check("rst_dma_active", DMA_ACTIVE, 0);
      check("rst_vmem_wr", VMEM_WR, 0);
      check("rst_src_rd", SRC_RD, 0);
      check("rst_src_addr", SRC_ADDR, 0);
      check("rst_vmem_addr", VMEM_ADDR, 0);
      check("rst_vmem_wdata", VMEM_WDATA, 0);
      check("rst_cpu_data", CPU_DATA_in, 8'hFF);
      check("rst_ppu_data", PPU_DATA_in, 8'hFF);
      @(posedge clk); #1;
      rst = 1'b0;
      idle_access(1'b0, 2'd0, 1'b1, 1'b0, 16'hFF46, 8'h00, 1'b0, 16'h0000);

      // Basic copy from C000
      for (int i = 0; i < 160; i++) srcmem[16'hC000 + 16'(i)] = 8'(i);
      dma_run(8'hC0, -1, 8'h00, -1, 1'b0);
      check_oam();
      idle_access(1'b0, 2'd0, 1'b1, 1'b0, 16'hFF46, 8'h00, 1'b0, 16'h0000);

      // Echo mirror and restarts (mid-transfer and on the final byte)
      dma_run(8'hE1, -1, 8'h00, -1, 1'b0);
      check_oam();
      dma_run(8'hC0, 50, 8'hD0, -1, 1'b0);
      check_oam();
      dma_run(8'($urandom), 159, 8'($urandom), -1, 1'b0);
      check_oam();

      // Lockout during DMA with the PPU in mode 2
      LCD_EN = 1'b1; PPU_MODE = 2'd2;
      dma_run(8'hC3, -1, 8'h00, -1, 1'b1);
      check_oam();
      LCD_EN = 1'b0; PPU_MODE = 2'd0;

      // Mode lockout with the DMA idle
      idle_access(1'b1, 2'd3, 1'b1, 1'b0, 16'h9800, 8'h00, 1'b1, 16'h9800);
      idle_access(1'b1, 2'd3, 1'b0, 1'b1, 16'h8000, 8'h5A, 1'b0, 16'h0000);
      idle_access(1'b1, 2'd0, 1'b1, 1'b0, 16'h8000, 8'h00, 1'b0, 16'h0000);
      idle_access(1'b1, 2'd0, 1'b1, 1'b0, 16'h9800, 8'h00, 1'b0, 16'h0000);
      idle_access(1'b0, 2'd3, 1'b1, 1'b0, 16'h9800, 8'h00, 1'b1, 16'h9800);
      idle_access(1'b0, 2'd3, 1'b0, 1'b1, 16'h9801, 8'h3C, 1'b0, 16'h0000);
      idle_access(1'b0, 2'd3, 1'b1, 1'b0, 16'h9801, 8'h00, 1'b0, 16'h0000);
      idle_access(1'b0, 2'd0, 1'b0, 1'b1, 16'hFEB0, 8'h77, 1'b0, 16'h0000);
      idle_access(1'b0, 2'd0, 1'b1, 1'b0, 16'hFEB0, 8'h00, 1'b0, 16'h0000);
      idle_access(1'b1, 2'd2, 1'b1, 1'b0, 16'hFE10, 8'h00, 1'b1, 16'hFE10);

      // Random idle traffic
      for (int n = 0; n < 300; n++) begin
         sel = int'($urandom_range(0, 2));
         a   = pick_addr(sel == 0);
         pa  = pick_addr(1'b0);
         idle_access(1'($urandom), 2'($urandom), sel == 0, sel == 1, a, 8'($urandom),
                     1'($urandom), pa);
      end

      // Random DMAs with random restarts and locked-out traffic
      for (int n = 0; n < 3; n++) begin
         LCD_EN = 1'($urandom); PPU_MODE = 2'($urandom_range(2, 3));
         dma_run(8'($urandom), ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 159)),
                 8'($urandom), -1, 1'b1);
         check_oam();
      end
      LCD_EN = 1'b0; PPU_MODE = 2'd0;

      // Asynchronous reset in the middle of a copy
      dma_run(8'hC0, -1, 8'h00, 80, 1'b0);
      idle_access(1'b0, 2'd0, 1'b1, 1'b0, 16'hFF46, 8'h00, 1'b0, 16'h0000);
      check_oam();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
